// File: rtl/clint_pkg.sv
// clint_pkg: shared offsets and mode encoding for the multi-hart CLINT.
// Offsets are relative to BASE_ADDR, low 16 bits of the bus address.
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MODE_OFF     = 16'h8000;
  localparam logic [15:0] PERIOD_OFF   = 16'h8400;
  localparam logic [15:0] PEND_OFF     = 16'hBFE8;
  localparam logic [15:0] PRESC_OFF    = 16'hBFF0;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/clint_hart_timer.sv
// clint_hart_timer: one hart's mtimecmp, mode, period, pending and timer irq.
// Ports: mtime_i, per-register write strobes + wdata_i, pend_clr_i, irq_en_i;
// outputs cmp_o/mode_o/period_o/pend_o for readback, irq_o (registered).
module clint_hart_timer
  import clint_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mtime_i,
  input  logic        cmp_lo_we_i,
  input  logic        cmp_hi_we_i,
  input  logic        mode_we_i,
  input  logic        period_we_i,
  input  logic [31:0] wdata_i,
  input  logic        pend_clr_i,
  input  logic        irq_en_i,
  output logic [63:0] cmp_o,
  output logic        mode_o,
  output logic [31:0] period_o,
  output logic        pend_o,
  output logic        irq_o
);

  logic [63:0] cmp_q, cmp_d;
  mode_e       mode_q, mode_d;
  logic [31:0] period_q, period_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;
  logic        hit, reload;

  assign hit    = mtime_i >= cmp_q;
  assign reload = (mode_q == MODE_PERIODIC) && hit;

  always_comb begin
    cmp_d = cmp_q;
    if (reload) cmp_d = cmp_q + {32'b0, period_q};
    // Software writes win over the auto-reload.
    if (cmp_lo_we_i) cmp_d = {cmp_q[63:32], wdata_i};
    if (cmp_hi_we_i) cmp_d = {wdata_i, cmp_q[31:0]};

    mode_d = mode_q;
    if (mode_we_i) mode_d = mode_e'(wdata_i[0]);

    period_d = period_we_i ? wdata_i : period_q;

    // W1C loses to a same-cycle set; leaving periodic mode drops it.
    pend_d = pend_q & ~pend_clr_i;
    if (reload) pend_d = 1'b1;
    if (mode_we_i && !wdata_i[0]) pend_d = 1'b0;

    irq_d = irq_en_i &
            ((mode_q == MODE_PERIODIC) ? pend_q : hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q    <= '1;
      mode_q   <= MODE_ONESHOT;
      period_q <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cmp_q    <= cmp_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

  assign cmp_o    = cmp_q;
  assign mode_o   = mode_q;
  assign period_o = period_q;
  assign pend_o   = pend_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/clint_mh.sv
// clint_mh: multi-hart CLINT; bus decode, prescaler, shared 64-bit mtime.
// Ports: bus_en/we/addr/wdata -> bus_rdata/bus_ready (1-cycle pulse),
// irq_enable gates timer_irq_o; software_irq_o mirrors msip.
// Define CLINT_MTIME_WRITE_EN to make mtime writable from the bus.
module clint_mh
  import clint_pkg::*;
#(
  parameter int          NUM_HARTS = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          PRESC_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_en,
  input  logic                 bus_we,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ready,
  input  logic [NUM_HARTS-1:0] irq_enable,
  output logic [NUM_HARTS-1:0] timer_irq_o,
  output logic [NUM_HARTS-1:0] software_irq_o
);

`ifdef CLINT_MTIME_WRITE_EN
  localparam bit MtimeWrEn = 1'b1;
`else
  localparam bit MtimeWrEn = 1'b0;
`endif

  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [63:0]        mtime_q, mtime_d;

  logic [31:0] offset;
  logic [15:0] off;
  logic        unused_off_hi;
  logic        req, wr, tick;
  logic [31:0] rd_mux;

  logic [NUM_HARTS-1:0] msip_sel, lo_sel, hi_sel;
  logic [NUM_HARTS-1:0] mode_sel, per_sel, pend_clr;

  logic [63:0] cmp_w [NUM_HARTS];
  logic [31:0] per_w [NUM_HARTS];
  logic [NUM_HARTS-1:0] mode_w, pend_w;

  assign offset        = bus_addr - BASE_ADDR;
  assign off           = offset[15:0];
  assign unused_off_hi = ^offset[31:16];

  // bus_en held during the ready cycle is the same request.
  assign req  = bus_en & ~ready_q;
  assign wr   = req & bus_we;
  assign tick = (cnt_q == presc_q);

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      msip_sel[h] = off == MSIP_OFF + 16'(4 * h);
      lo_sel[h]   = off == MTIMECMP_OFF + 16'(8 * h);
      hi_sel[h]   = off == MTIMECMP_OFF + 16'(8 * h + 4);
      mode_sel[h] = off == MODE_OFF + 16'(4 * h);
      per_sel[h]  = off == PERIOD_OFF + 16'(4 * h);
      pend_clr[h] = wr && (off == PEND_OFF) && bus_wdata[h];
      msip_d[h]   = (wr && msip_sel[h]) ? bus_wdata[0]
                                        : msip_q[h];
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msip_sel[h]) rd_mux = {31'b0, msip_q[h]};
      if (lo_sel[h])   rd_mux = cmp_w[h][31:0];
      if (hi_sel[h])   rd_mux = cmp_w[h][63:32];
      if (mode_sel[h]) rd_mux = {31'b0, mode_w[h]};
      if (per_sel[h])  rd_mux = per_w[h];
    end
    if (off == PEND_OFF)  rd_mux[NUM_HARTS-1:0] = pend_w;
    if (off == PRESC_OFF) rd_mux[PRESC_W-1:0] = presc_q;
    if (off == MTIME_OFF) rd_mux = mtime_q[31:0];
    if (off == MTIME_OFF + 16'd4) rd_mux = mtime_q[63:32];
  end

  always_comb begin
    ready_d = req;
    rdata_d = (req && !bus_we) ? rd_mux : '0;

    presc_d = presc_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    if (wr && off == PRESC_OFF) begin
      presc_d = bus_wdata[PRESC_W-1:0];
      cnt_d   = '0;
    end

    mtime_d = mtime_q + {63'b0, tick};
    if (MtimeWrEn && wr && off == MTIME_OFF)
      mtime_d = {mtime_q[63:32], bus_wdata};
    if (MtimeWrEn && wr && off == MTIME_OFF + 16'd4)
      mtime_d = {bus_wdata, mtime_q[31:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      msip_q  <= '0;
      presc_q <= '0;
      cnt_q   <= '0;
      mtime_q <= '0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      msip_q  <= msip_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      mtime_q <= mtime_d;
    end
  end

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    clint_hart_timer u_timer (
      .clk         (clk),
      .rst         (rst),
      .mtime_i     (mtime_q),
      .cmp_lo_we_i (wr & lo_sel[g]),
      .cmp_hi_we_i (wr & hi_sel[g]),
      .mode_we_i   (wr & mode_sel[g]),
      .period_we_i (wr & per_sel[g]),
      .wdata_i     (bus_wdata),
      .pend_clr_i  (pend_clr[g]),
      .irq_en_i    (irq_enable[g]),
      .cmp_o       (cmp_w[g]),
      .mode_o      (mode_w[g]),
      .period_o    (per_w[g]),
      .pend_o      (pend_w[g]),
      .irq_o       (timer_irq_o[g])
    );
  end

  assign bus_ready      = ready_q;
  assign bus_rdata      = rdata_q;
  assign software_irq_o = msip_q;

endmodule

// File: tb/tb_clint_mh.sv
// tb_clint_mh: directed/randomised bench for clint_mh (4 harts).
// mtime is modelled as elapsed cycles plus a measured offset.
module tb_clint_mh;

  localparam logic [31:0] B = 32'h0200_0000;
  localparam logic [31:0] A_MTIME = B + 32'hBFF8;
  localparam logic [31:0] A_PEND  = B + 32'hBFE8;
  localparam logic [31:0] A_PRESC = B + 32'hBFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_en = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [3:0]  irq_enable = '0;
  logic [3:0]  timer_irq_o;
  logic [3:0]  software_irq_o;

  int     checks = 0;
  int     errors = 0;
  longint ncyc = 0;
  logic [3:0] sw_snap;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;

  clint_mh dut (
    .clk            (clk),
    .rst            (rst),
    .bus_en         (bus_en),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ready      (bus_ready),
    .irq_enable     (irq_enable),
    .timer_irq_o    (timer_irq_o),
    .software_irq_o (software_irq_o)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    bus_en = 1'b1; bus_we = 1'b1;
    bus_addr = a;  bus_wdata = d;
    @(posedge clk); #1;
    chk("wr_ready", bus_ready, 1);
    sw_snap = software_irq_o;
    bus_en = 1'b0; bus_we = 1'b0;
    @(posedge clk);
  endtask

  task automatic bus_rd(input  logic [31:0] a,
                        output logic [31:0] d,
                        output longint c);
    @(negedge clk);
    c = ncyc;
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    @(posedge clk); #1;
    chk("rd_ready", bus_ready, 1);
    d = bus_rdata;
    bus_en = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, r1, r2, ccmp, c1;
    logic [3:0]  pat;
    longint c, ca, cb, off, f1, f2, e, dd;
    int p, dly, per;
    bit got;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tirq", timer_irq_o, 0);
    chk("rst_sirq", software_irq_o, 0);
    chk("rst_ready", bus_ready, 0);
    chk("rst_rdata", bus_rdata, 0);
    rst = 1'b0;

    // prescale 0: mtime equals edges since reset
    bus_rd(A_MTIME, r1, ca);
    chk("mtime_exact", r1, ca);
    repeat (10) @(negedge clk);
    bus_rd(A_MTIME, r2, cb);
    chk("mtime_delta", r2 - r1, cb - ca);
    chk("mtime_ge10", (r2 - r1) >= 10, 1);
    bus_rd(A_MTIME + 4, r, c);
    chk("mtime_hi", r, 0);
    bus_rd(B + 32'h4004, r, c);
    chk("cmp0_hi_rst", r, 32'hFFFF_FFFF);

    // prescaler rate
    p = $urandom_range(2, 5);
    bus_wr(A_PRESC, p);
    bus_rd(A_PRESC, r, c);
    chk("presc_rd", r, p);
    bus_rd(A_MTIME, r1, ca);
    repeat (40) @(negedge clk);
    bus_rd(A_MTIME, r2, cb);
    e  = (cb - ca) / (p + 1);
    dd = longint'(r2 - r1);
    chk("presc_rate", (dd >= e - 1) && (dd <= e + 1), 1);
    bus_wr(A_PRESC, 0);
    irq_enable = 4'hF;

    // hart 2 one-shot, checked cycle by cycle
    dly = $urandom_range(12, 18);
    bus_rd(A_MTIME, r, c);
    off  = longint'(r) - c;
    ccmp = r + dly;
    bus_wr(B + 32'h4010, ccmp);
    bus_wr(B + 32'h4014, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("os_irq", timer_irq_o[2],
          (ncyc - 1 + off) >= longint'(ccmp));
    end
    chk("os_others", timer_irq_o & 4'b1011, 0);
    bus_wr(B + 32'h4014, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("os_drop", timer_irq_o[2], 0);

    // hart 1 periodic
    per = $urandom_range(15, 25);
    bus_wr(B + 32'h8404, per);
    bus_wr(B + 32'h8004, 1);
    bus_rd(A_MTIME, r, c);
    off = longint'(r) - c;
    c1  = r + 16;
    bus_wr(B + 32'h4008, c1);
    bus_wr(B + 32'h400C, 0);
    got = 0; f1 = -1;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (timer_irq_o[1]) begin got = 1; f1 = ncyc; end
    end
    chk("per_rise1", got, 1);
    chk("per_t1", f1, longint'(c1) - off + 2);
    bus_rd(A_PEND, r, c);
    chk("per_pend", r, 32'h2);
    bus_wr(A_PEND, 32'h2);
    @(negedge clk);
    chk("per_w1c_drop", timer_irq_o[1], 0);
    got = 0; f2 = -1;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (timer_irq_o[1]) begin got = 1; f2 = ncyc; end
    end
    chk("per_rise2", got, 1);
    chk("per_t2", f2, f1 + per);
    bus_rd(B + 32'h4008, r, c);
    chk("per_cmp", r, c1 + 32'(2 * per));

    // software irq and enable masking
    bus_wr(B + 32'h000C, 1);
    chk("sw_set", sw_snap, 4'b1000);
    bus_rd(B + 32'h000C, r, c);
    chk("msip_rd", r, 1);
    irq_enable = 4'h0;
    @(negedge clk); @(negedge clk);
    chk("mask_tirq", timer_irq_o, 0);
    chk("mask_sirq", software_irq_o, 4'b1000);
    bus_wr(A_PEND, 32'h2);
    repeat (per + 3) @(negedge clk);
    bus_rd(A_PEND, r, c);
    chk("pend_ungated", r & 32'h2, 32'h2);
    chk("mask_tirq2", timer_irq_o, 0);
    bus_wr(B + 32'h000C, 0);
    chk("sw_clr", sw_snap, 0);
    bus_wr(B + 32'h0010, 1);
    chk("sw_hart4", sw_snap, 0);
    bus_rd(B + 32'h0010, r, c);
    chk("msip4_rd", r, 0);

    pat = 4'($urandom_range(0, 15));
    for (int h = 0; h < 4; h++)
      bus_wr(B + 32'(4 * h), {31'b0, pat[h]});
    chk("sw_pat", software_irq_o, pat);

    // leaving periodic mode drops pending
    bus_wr(B + 32'h8004, 0);
    bus_rd(A_PEND, r, c);
    chk("mode_clr_pend", r, 0);

    bus_rd(B + 32'h9000, r, c);
    chk("unmapped", r, 0);
    @(negedge clk);
    chk("idle_rdata", bus_rdata, 0);
    chk("idle_ready", bus_ready, 0);

    // mtime write
    bus_rd(A_MTIME, r1, c);
    bus_wr(A_MTIME, 32'h5);
    bus_rd(A_MTIME, r2, c);
`ifdef CLINT_MTIME_WRITE_EN
    chk("mtime_wr", (r2 >= 5) && (r2 <= 8), 1);
`else
    chk("mtime_ro", r2 > r1, 1);
`endif

    // reset mid-transaction
    @(negedge clk);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = A_MTIME;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_abort_rdy", bus_ready, 0);
    chk("rst_abort_rd", bus_rdata, 0);
    bus_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus_rd(B + 32'h4014, r, c);
    chk("rst_cmp2_hi", r, 32'hFFFF_FFFF);
    chk("rst_sirq2", software_irq_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_mh.md
Name: clint_mh

Overview:
- Parametrised multi-hart successor to the single-hart CLINT.
- Provides one shared 64-bit mtime with a programmable prescaler, plus a per-hart msip, mtimecmp, mode register and auto-reload period.
- Supports one-shot (level) and periodic (latched, auto-reload) timer modes per hart.
- Sits on the core peripheral bus, using the same bus_en/bus_we/bus_ready handshake as the existing CLINT, and drives the per-hart MIP timer/software lines.

Parameters:
- NUM_HARTS, 4, number of harts (1..16).
- BASE_ADDR, 32'h0200_0000, region base; decode uses offset = bus_addr - BASE_ADDR, bits [15:0].
- PRESC_W, 8, prescaler register/counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- bus_en  in  1  request valid.
- bus_we  in  1  1 = write, 0 = read.
- bus_addr  in  32  byte address, word aligned.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, valid while bus_ready = 1.
- bus_ready  out  1  one-cycle completion pulse.
- irq_enable  in  NUM_HARTS  per-hart timer interrupt gate.
- timer_irq_o  out  NUM_HARTS  per-hart timer interrupt.
- software_irq_o  out  NUM_HARTS  per-hart software interrupt.

Behaviour:
- Reset. While rst is high at a clk edge:
  - mtime = 0, mtimecmp[h] = all-ones, msip = 0, mode = 0, period = 0, prescale = 0, pending = 0, presc_cnt = 0.
  - All outputs are 0.
- Register map (offset; any unmapped offset reads 0 and ignores writes):
  - 0x0000 + 4h: msip[h], bit 0.
  - 0x4000 + 8h: mtimecmp[h] low word; +4: high word.
  - 0x8000 + 4h: mode[h], bit 0 (0 = one-shot, 1 = periodic).
  - 0x8400 + 4h: period[h], 32 bits, zero-extended to 64.
  - 0xBFE8: pending bitmap (read); write-1-to-clear (W1C).
  - 0xBFF0: prescale, PRESC_W bits.
  - 0xBFF8 / 0xBFFC: mtime low / high.
  - Hart indices h >= NUM_HARTS are unmapped.
- Handshake:
  - A request is accepted on any edge where bus_en = 1 and bus_ready = 0.
  - bus_ready pulses high for exactly the next cycle; bus_rdata is registered in that same cycle.
  - bus_en still high while bus_ready = 1 is not a new request, so back-to-back transfers complete at most every 2 cycles.
  - bus_rdata = 0 whenever bus_ready = 0.
  - Writes take effect at the accepting edge.
- Timebase:
  - presc_cnt increments every cycle.
  - When presc_cnt == prescale, a tick occurs: presc_cnt resets to 0 and mtime increments by 1.
  - prescale = 0 ticks every cycle; mtime wraps at 2^64.
  - Writing prescale also clears presc_cnt.
- Compare: hit[h] = (mtime >= mtimecmp[h]), 64-bit unsigned.
- One-shot mode: timer_irq_o[h] is registered as hit[h] & irq_enable[h], one cycle of latency; it is a level that follows hit.
- Periodic mode:
  - On each cycle with hit[h] = 1 the block sets pending[h] and adds period[h] to mtimecmp[h] (64-bit wrap).
  - timer_irq_o[h] is registered as pending[h] & irq_enable[h].
  - period = 0 leaves mtimecmp unchanged, so pending re-sets every cycle until mtimecmp is rewritten.
  - irq_enable does not gate the setting of pending.
- software_irq_o[h] = registered msip[h]; it asserts in the cycle after the write edge.
- Simultaneous events:
  - A bus write to mtimecmp[h] overrides the auto-reload in the same cycle.
  - A W1C clear and a new set in the same cycle: set wins.
  - A bus write to mtime overrides the tick increment.
  - Switching mode to one-shot clears pending[h].
- Reset asserted mid-transaction aborts it; no bus_ready is issued.

Optional Feature:
- CLINT_MTIME_WRITE_EN.
  - Defined: mtime low/high words are writable.
  - Undefined: mtime is read-only; writes complete normally (bus_ready pulses) but have no effect.

Decomposition:
- Package clint_pkg holds:
  - offset constants: MSIP_OFF, MTIMECMP_OFF, MODE_OFF, PERIOD_OFF, PEND_OFF, PRESC_OFF, MTIME_OFF;
  - mode enum: MODE_ONESHOT, MODE_PERIODIC.
- Sub-module clint_hart_timer (one instance per hart via generate) holds that hart's mtimecmp, mode, period, pending, compare, reload and irq register.
- The top level holds bus decode, the prescaler and mtime.

Test Plan:
- Reset, then two mtime reads 10 cycles apart with prescale = 0 -> second value larger by at least 10; all irq outputs 0.
- Write prescale = 3, run 40 cycles -> mtime advances by 10 (±1).
- Hart 2 one-shot: mtimecmp = mtime + 10 -> timer_irq_o[2] rises about 11 cycles later; write all-ones to high word -> irq drops the next cycle; other harts stay 0.
- Hart 1 periodic, period 20: after the first fire, W1C pending 0x2 -> irq drops, re-asserts 20 ticks after the previous fire; mtimecmp reads previous value + 20.
- msip[3] = 1 -> software_irq_o = 4'b1000 one cycle after the write edge; write 0 -> cleared; irq_enable = 0 masks timer_irq_o only.
- Write mtime = 0x0000_0005 -> reads back near 5 with CLINT_MTIME_WRITE_EN defined, unchanged without it; an unmapped read (0x9000) returns 0 with a bus_ready pulse.
